// File: rtl/lsu.sv
// Load/store unit: one request/acknowledge transaction per access against the data memory,
// with byte-lane store steering, sign/zero-extended loads and misalign/illegal/timeout errors.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] alu_c,
    input  logic [31:0] rD2,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        dram_req,
    output logic        dram_we,
    output logic [29:0] dram_addr,
    output logic [3:0]  dram_wmask,
    output logic [31:0] dram_wdata,
    input  logic        dram_ack,
    input  logic [31:0] dram_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_nxt;
    logic        err_q, err_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic        illegal, misaligned;
    logic [31:0] byte_shift, ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // BU/HU exist only as loads; 011 and 11x are not defined for loads or stores.
    assign illegal    = (lsu_funct3 == 3'b011) || (lsu_funct3[2:1] == 2'b11) ||
                        (lsu_we && lsu_funct3[2]);
    assign misaligned = ((lsu_funct3[1:0] == 2'b01) && alu_c[0]) ||
                        ((lsu_funct3[1:0] == 2'b10) && (alu_c[1:0] != 2'b00));

    assign byte_shift = dram_rdata >> {addr_q[1:0], 3'b000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = addr_q[1] ? dram_rdata[31:16] : dram_rdata[15:0];

    always_comb begin
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dram_rdata;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        rdata_nxt = rdata_q;
        case (state)
            IDLE: if (lsu_req) begin
                rdata_nxt = 32'h0;
                if (illegal || misaligned) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end else begin
                    state_nxt = REQ;
                    cnt_nxt   = 8'h0;
                    err_nxt   = 1'b0;
                end
            end
            REQ: if (dram_ack) begin
                state_nxt = DONE;
                err_nxt   = 1'b0;
                rdata_nxt = we_q ? 32'h0 : ld_data;
            end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
                rdata_nxt = 32'h0;
            end else begin
                cnt_nxt = cnt_q + 8'h1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt_q    <= 8'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            err_q   <= err_nxt;
            rdata_q <= rdata_nxt;
            if (state == IDLE && lsu_req) begin
                we_q     <= lsu_we;
                funct3_q <= lsu_funct3;
                addr_q   <= alu_c;
                wdata_q  <= rD2;
            end
        end
    end

    always_comb begin
        dram_wmask = 4'b1111;
        dram_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                dram_wmask = 4'b0001 << addr_q[1:0];
                dram_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                dram_wmask = 4'b0011 << addr_q[1:0];
                dram_wdata = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
        if (!(state == REQ && we_q)) dram_wmask = 4'b0000;
    end

    assign dram_req  = (state == REQ);
    assign dram_we   = (state == REQ) && we_q;
    assign dram_addr = addr_q[31:2];
    assign lsu_done  = (state == DONE);
    assign lsu_err   = (state == DONE) && err_q;
    assign lsu_rdata = rdata_q;
    assign lsu_busy  = !rst && ((state != IDLE) || lsu_req);
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset/late-ack sequence and random
// accesses compared against a byte-level reference model.
module tb_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = 3'b000;
    logic [31:0] alu_c = 32'h0, rD2 = 32'h0;
    logic        lsu_busy, lsu_done, lsu_err, dram_req, dram_we;
    logic [31:0] lsu_rdata, dram_wdata;
    logic [29:0] dram_addr;
    logic [3:0]  dram_wmask;
    logic        dram_ack = 1'b0;
    logic [31:0] dram_rdata = 32'h0;

    int checks = 0;
    int failures = 0;

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
        .alu_c(alu_c), .rD2(rD2), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
        .lsu_rdata(lsu_rdata), .lsu_err(lsu_err), .dram_req(dram_req), .dram_we(dram_we),
        .dram_addr(dram_addr), .dram_wmask(dram_wmask), .dram_wdata(dram_wdata),
        .dram_ack(dram_ack), .dram_rdata(dram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mem;
        int          waits;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        int          exp_done;
        int          exp_reqs;
    } vec_t;

    typedef struct {
        int          done_k;
        int          reqs;
        logic        err;
        logic [31:0] rdata;
        logic [29:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        bit          stable;
    } obs_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: access size from funct3, lanes and extension by byte arithmetic.
    task automatic model(input vec_t v, output vec_t e);
        int          size, off;
        logic [63:0] val, lim;
        e = v;
        size = (v.f3[1:0] == 2'b00) ? 1 : (v.f3[1:0] == 2'b01) ? 2 : 4;
        off  = int'(v.addr % 4);
        e.exp_mask = 4'h0; e.exp_wdata = 32'h0; e.exp_rdata = 32'h0;
        if (v.f3 == 3 || v.f3 == 6 || v.f3 == 7 || (v.we && v.f3 >= 4) || (v.addr % size) != 0) begin
            e.exp_err = 1'b1; e.exp_done = 1; e.exp_reqs = 0;
            return;
        end
        if (v.we) begin
            e.exp_mask = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) e.exp_wdata[8*i +: 8] = v.wd[8*(i % size) +: 8];
        end
        if (v.waits >= TO) begin
            e.exp_err = 1'b1; e.exp_done = TO + 1; e.exp_reqs = TO;
            return;
        end
        e.exp_err = 1'b0; e.exp_done = v.waits + 2; e.exp_reqs = v.waits + 1;
        if (!v.we) begin
            lim = (64'd1 << (8 * size)) - 64'd1;
            val = (64'(v.mem) >> (8 * off)) & lim;
            if (v.f3 < 4 && size < 4 && val[8*size-1]) val = val | ~lim;
            e.exp_rdata = val[31:0];
        end
    endtask

    // Entered just after a rising edge with the DUT idle; returns just after a rising edge.
    task automatic run_txn(input vec_t v, input string tag, output obs_t o);
        int k;
        o.done_k = -1; o.reqs = 0; o.err = 1'b0; o.rdata = 32'h0; o.stable = 1'b1;
        o.addr = '0; o.we = 1'b0; o.mask = '0; o.wdata = '0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(lsu_busy), 32'h0);
        lsu_req = 1'b1; lsu_we = v.we; lsu_funct3 = v.f3; alu_c = v.addr; rD2 = v.wd;
        dram_ack = ($urandom_range(0, 3) == 0);
        dram_rdata = $urandom;
        #1 check({tag, "_req_busy"}, 32'(lsu_busy), 32'h1);
        @(posedge clk);
        #1 lsu_req = 1'b0; dram_ack = 1'b0;
        for (k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (lsu_done) begin
                o.done_k = k; o.err = lsu_err; o.rdata = lsu_rdata;
                break;
            end
            if (dram_req) begin
                o.reqs++;
                if (o.reqs == 1) begin
                    o.addr = dram_addr; o.we = dram_we; o.mask = dram_wmask; o.wdata = dram_wdata;
                end else if (dram_addr !== o.addr || dram_we !== o.we ||
                             dram_wmask !== o.mask || dram_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                if (o.reqs == v.waits + 1) begin
                    dram_ack = 1'b1;
                    dram_rdata = v.mem;
                end
            end
            @(posedge clk);
            #1 dram_ack = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input vec_t e, input obs_t o, input string tag);
        check({tag, "_done_cycle"}, 32'(o.done_k), 32'(e.exp_done));
        check({tag, "_req_cycles"}, 32'(o.reqs), 32'(e.exp_reqs));
        check({tag, "_err"}, 32'(o.err), 32'(e.exp_err));
        check({tag, "_rdata"}, o.rdata, e.exp_rdata);
        if (o.reqs > 0) begin
            check({tag, "_addr"}, 32'(o.addr), 32'(e.addr[31:2]));
            check({tag, "_we"}, 32'(o.we), 32'(e.we));
            check({tag, "_wmask"}, 32'(o.mask), 32'(e.exp_mask));
            check({tag, "_stable"}, 32'(o.stable), 32'h1);
            if (e.we) check({tag, "_wdata"}, o.wdata, e.exp_wdata);
        end
    endtask

    vec_t vecs[15];
    vec_t v, e;
    obs_t o;

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF, 2, 1};
        vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1'b0, 32'h0, 4'h8, 32'hA5A5A5A5, 2, 1};
        vecs[2]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1, 1'b0, 32'h0, 4'hC, 32'h12341234, 3, 2};
        vecs[3]  = '{1'b0, 3'b000, 32'h1, 32'h0, 32'h80FF7F01, 0, 1'b0, 32'h0000007F, 4'h0, 32'h0, 2, 1};
        vecs[4]  = '{1'b0, 3'b000, 32'h2, 32'h0, 32'h80FF7F01, 1, 1'b0, 32'hFFFFFFFF, 4'h0, 32'h0, 3, 2};
        vecs[5]  = '{1'b0, 3'b100, 32'h3, 32'h0, 32'h80FF7F01, 2, 1'b0, 32'h00000080, 4'h0, 32'h0, 4, 3};
        vecs[6]  = '{1'b0, 3'b001, 32'h2, 32'h0, 32'h80FF7F01, 0, 1'b0, 32'hFFFF80FF, 4'h0, 32'h0, 2, 1};
        vecs[7]  = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h80FF7F01, 0, 1'b0, 32'h000080FF, 4'h0, 32'h0, 2, 1};
        vecs[8]  = '{1'b0, 3'b010, 32'h0, 32'h0, 32'h80FF7F01, 0, 1'b0, 32'h80FF7F01, 4'h0, 32'h0, 2, 1};
        vecs[9]  = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h80FF7F01, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1, 0};
        vecs[10] = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h80FF7F01, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1, 0};
        vecs[11] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h80FF7F01, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1, 0};
        vecs[12] = '{1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 1, 0};
        vecs[13] = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h80FF7F01, 10, 1'b1, 32'h0, 4'h0, 32'h0, 5, 4};
        vecs[14] = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h80FF7F01, 3, 1'b0, 32'h80FF7F01, 4'h0, 32'h0, 5, 4};

        // Reset values while rst is held.
        #12;
        check("rst_busy", 32'(lsu_busy), 32'h0);
        check("rst_done", 32'(lsu_done), 32'h0);
        check("rst_err", 32'(lsu_err), 32'h0);
        check("rst_dram_req", 32'(dram_req), 32'h0);
        check("rst_dram_we", 32'(dram_we), 32'h0);
        check("rst_rdata", lsu_rdata, 32'h0);
        check("rst_addr", 32'(dram_addr), 32'h0);
        check("rst_wmask", 32'(dram_wmask), 32'h0);
        check("rst_wdata", dram_wdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_txn(vecs[i], $sformatf("v%0d", i), o);
            compare(vecs[i], o, $sformatf("v%0d", i));
        end

        // Reset on the second REQ cycle, then a stray ack, then a normal load.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b010; alu_c = 32'h200; rD2 = 32'hCAFEF00D;
        @(posedge clk);
        #1 lsu_req = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(dram_req), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(lsu_busy), 32'h0);
        check("mid_rst_req", 32'(dram_req), 32'h0);
        check("mid_rst_we", 32'(dram_we), 32'h0);
        check("mid_rst_addr", 32'(dram_addr), 32'h0);
        check("mid_rst_wmask", 32'(dram_wmask), 32'h0);
        check("mid_rst_wdata", dram_wdata, 32'h0);
        check("mid_rst_done", 32'(lsu_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        dram_ack = 1'b1; dram_rdata = 32'h12345678;
        @(posedge clk);
        #1 dram_ack = 1'b0;
        @(negedge clk);
        check("late_ack_done", 32'(lsu_done), 32'h0);
        check("late_ack_req", 32'(dram_req), 32'h0);
        check("late_ack_busy", 32'(lsu_busy), 32'h0);
        @(posedge clk);
        #1;
        run_txn(vecs[8], "post_rst", o);
        compare(vecs[8], o, "post_rst");

        // Random accesses against the reference model.
        for (int n = 0; n < 150; n++) begin
            v.we = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wd = $urandom;
            v.mem = $urandom;
            v.waits = $urandom_range(0, 5);
            v.exp_err = 1'b0; v.exp_rdata = '0; v.exp_mask = '0; v.exp_wdata = '0;
            v.exp_done = 0; v.exp_reqs = 0;
            model(v, e);
            run_txn(v, $sformatf("r%0d", n), o);
            compare(e, o, $sformatf("r%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
